// File: rtl/alu_pkg.sv
// alu_pkg: op codes, sequencer states, error bit positions and per-op latency shared by the ALU sequencer
package alu_pkg;
  localparam logic [3:0] OP_ADD = 4'd0, OP_MOD = 4'd1, OP_DIV = 4'd2, OP_RESET = 4'd3;
  localparam logic [3:0] OP_MUL = 4'd4, OP_AND = 4'd5, OP_OR = 4'd6, OP_NAND = 4'd7;
  localparam logic [3:0] OP_SUB = 4'd8, OP_NOR = 4'd9, OP_XOR = 4'd10, OP_XNOR = 4'd11;
  localparam logic [3:0] OP_NOT = 4'd12, OP_NOOP = 4'd13, OP_ZERO = 4'd14, OP_PRESET = 4'd15;
  localparam logic [1:0] IDLE = 2'd0, EXEC = 2'd1, RESP = 2'd2;
  localparam int ERR_DIVZERO = 1;
  localparam int ERR_OVF = 0;
  typedef struct packed {
    logic [3:0]  op;
    logic [15:0] operand;
  } cmd_t;
  function automatic logic [7:0] lat_of(input logic [3:0] op, input int muldiv_lat, input int base_lat);
    return 8'((op == OP_MOD || op == OP_DIV || op == OP_MUL) ? muldiv_lat : base_lat);
  endfunction
endpackage

// File: rtl/cmd_fifo.sv
// cmd_fifo: count-based synchronous FIFO with first-word-fall-through output
module cmd_fifo #(
  parameter int DEPTH = 4,
  parameter int W = 20
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push_i,
  input  logic         pop_i,
  input  logic [W-1:0] din_i,
  output logic [W-1:0] dout_o,
  output logic         full_o,
  output logic         empty_o
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0] mem_q [DEPTH];
  logic [AW-1:0] wp_q, rp_q;
  logic [AW:0] cnt_q;
  logic do_push, do_pop;
  assign full_o = cnt_q == (AW+1)'(DEPTH);
  assign empty_o = cnt_q == '0;
  assign do_push = push_i && !full_o;
  assign do_pop = pop_i && !empty_o;
  assign dout_o = mem_q[rp_q];
  always_ff @(posedge clk) begin
    if (rst) begin
      wp_q <= '0;
      rp_q <= '0;
      cnt_q <= '0;
    end else begin
      wp_q <= do_push ? wp_q + 1'b1 : wp_q;
      rp_q <= do_pop ? rp_q + 1'b1 : rp_q;
      cnt_q <= cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end
  always_ff @(posedge clk)
    if (do_push) mem_q[wp_q] <= din_i;
endmodule

// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer: queues ALU commands, drives the datapath, commits results into the accumulator
module alu_op_sequencer
  import alu_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int MULDIV_LAT = 4,
  parameter int BASE_LAT = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [3:0]  cmd_op,
  input  logic [15:0] cmd_operand,
  output logic [3:0]  alu_op_code,
  output logic [15:0] alu_input_a,
  input  logic [31:0] alu_result,
  input  logic        alu_error,
  output logic [31:0] acc,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_result,
  output logic [1:0]  rsp_err,
  output logic        busy
);
  logic [1:0] state_q, state_d;
  logic [3:0] op_q, op_d;
  logic [15:0] opnd_q, opnd_d;
  logic [7:0] cnt_q, cnt_d;
  logic [31:0] acc_q, acc_d, res_q, res_d;
  logic [1:0] err_q, err_d, err;
  logic full, empty, pop, done, divz, keep;
  cmd_t head;
  cmd_fifo #(.DEPTH(FIFO_DEPTH), .W(20)) u_fifo (
    .clk(clk),
    .rst(rst),
    .push_i(cmd_valid),
    .pop_i(pop),
    .din_i({cmd_op, cmd_operand}),
    .dout_o(head),
    .full_o(full),
    .empty_o(empty)
  );
  assign cmd_ready = !full;
  assign alu_op_code = state_q == EXEC ? op_q : OP_NOOP;
  assign alu_input_a = opnd_q;
  assign acc = acc_q;
  assign rsp_valid = state_q == RESP;
  assign rsp_result = res_q;
  assign rsp_err = err_q;
  assign busy = state_q != IDLE || !empty;
  always_comb begin
    pop = state_q == IDLE && !empty;
    done = state_q == EXEC && cnt_q == 8'd0;
    divz = (op_q == OP_DIV || op_q == OP_MOD) && acc_q[15:0] == 16'd0;
    keep = divz || op_q == OP_NOOP;
    err = '0;
    err[ERR_DIVZERO] = divz;
    err[ERR_OVF] = !divz && (op_q == OP_ADD || op_q == OP_SUB) && alu_error;
    state_d = pop ? EXEC : done ? RESP : (state_q == RESP && rsp_ready) ? IDLE : state_q;
    op_d = pop ? head.op : op_q;
    opnd_d = pop ? head.operand : opnd_q;
    cnt_d = pop ? lat_of(head.op, MULDIV_LAT, BASE_LAT) - 8'd1 : state_q == EXEC ? cnt_q - 8'd1 : cnt_q;
    acc_d = done && !keep ? alu_result : acc_q;
    res_d = !done ? res_q : divz ? 32'hFFFF_FFFF : keep ? acc_q : alu_result;
    err_d = done ? err : err_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      op_q <= OP_NOOP;
      opnd_q <= '0;
      cnt_q <= '0;
      acc_q <= '0;
      res_q <= '0;
      err_q <= '0;
    end else begin
      state_q <= state_d;
      op_q <= op_d;
      opnd_q <= opnd_d;
      cnt_q <= cnt_d;
      acc_q <= acc_d;
      res_q <= res_d;
      err_q <= err_d;
    end
  end
endmodule

// File: tb/tb_alu_op_sequencer.sv
// tb_alu_op_sequencer: scoreboard bench with a behavioural 16-bit ALU closing the datapath loop
module tb_alu_op_sequencer;
  import alu_pkg::*;
  localparam int ML = 4, BL = 1;
  logic clk = 0, rst = 1, cmd_valid = 0, rsp_ready = 1, force_err = 0;
  logic [3:0] cmd_op = 0;
  logic [15:0] cmd_operand = 0;
  logic cmd_ready, alu_error, rsp_valid, busy;
  logic [3:0] alu_op_code;
  logic [15:0] alu_input_a;
  logic [31:0] alu_result, acc, rsp_result;
  logic [1:0] rsp_err;
  int total = 0, bad = 0, cyc = 0;
  typedef struct {
    logic [31:0] r;
    logic [1:0]  e;
    logic [31:0] a;
  } exp_t;
  exp_t sb[$];
  exp_t mon_x;
  logic [31:0] macc = 0;

  alu_op_sequencer #(.FIFO_DEPTH(4), .MULDIV_LAT(ML), .BASE_LAT(BL)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_operand(cmd_operand), .alu_op_code(alu_op_code),
    .alu_input_a(alu_input_a), .alu_result(alu_result), .alu_error(alu_error),
    .acc(acc), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_result(rsp_result), .rsp_err(rsp_err), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] alu_f(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b);
    case (op)
      OP_ADD:    return 32'(a) + 32'(b);
      OP_SUB:    return 32'(a) - 32'(b);
      OP_MUL:    return 32'(a) * 32'(b);
      OP_DIV:    return b == 0 ? 32'd0 : 32'(a / b);
      OP_MOD:    return b == 0 ? 32'd0 : 32'(a % b);
      OP_AND:    return {16'h0, a & b};
      OP_OR:     return {16'h0, a | b};
      OP_NAND:   return {16'h0, ~(a & b)};
      OP_NOR:    return {16'h0, ~(a | b)};
      OP_XOR:    return {16'h0, a ^ b};
      OP_XNOR:   return {16'h0, ~(a ^ b)};
      OP_NOT:    return {16'h0, ~a};
      OP_PRESET: return 32'h0000_FFFF;
      OP_NOOP:   return 32'(b);
      default:   return 32'd0;
    endcase
  endfunction

  assign alu_result = alu_f(alu_op_code, alu_input_a, acc[15:0]);
  assign alu_error = force_err;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic sb_push(input logic [3:0] op, input logic [15:0] v);
    exp_t x;
    logic dz;
    dz = (op == OP_DIV || op == OP_MOD) && macc[15:0] == 16'd0;
    if (dz) begin
      x.r = 32'hFFFF_FFFF; x.e = 2'b10; x.a = macc;
    end else if (op == OP_NOOP) begin
      x.r = macc; x.e = 2'b00; x.a = macc;
    end else begin
      x.r = alu_f(op, v, macc[15:0]);
      x.e = (op == OP_ADD || op == OP_SUB) ? {1'b0, force_err} : 2'b00;
      x.a = x.r;
    end
    macc = x.a;
    sb.push_back(x);
  endtask

  always @(negedge clk)
    if (!rst && rsp_valid && rsp_ready) begin
      chk("sb_nonempty", 32'(sb.size() != 0), 1);
      if (sb.size() != 0) begin
        mon_x = sb.pop_front();
        chk("rsp_result", rsp_result, mon_x.r);
        chk("rsp_err", 32'(rsp_err), 32'(mon_x.e));
        chk("rsp_acc", acc, mon_x.a);
      end
    end

  task automatic try_push(input logic [3:0] op, input logic [15:0] v, output bit ok);
    cmd_op = op;
    cmd_operand = v;
    cmd_valid = 1;
    ok = cmd_ready;
    @(posedge clk); #1;
    cmd_valid = 0;
    if (ok) sb_push(op, v);
  endtask

  task automatic push(input logic [3:0] op, input logic [15:0] v);
    int n = 0;
    bit ok;
    do begin
      try_push(op, v, ok);
      n++;
    end while (!ok && n < 50);
    chk("push_accept", 32'(ok), 1);
  endtask

  task automatic wait_rsp(output int t);
    int n = 0;
    while (!rsp_valid && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    chk("rsp_wait", 32'(rsp_valid), 1);
    t = cyc;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    chk("idle", 32'(busy), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int ta, t0, t1, t2, n_acc;
    bit ok;
    logic [31:0] r0, a0;
    logic [1:0] e0;
    logic [3:0] ops[6];
    logic [15:0] vals[6];
    ops = '{OP_ADD, OP_XOR, OP_OR, OP_SUB, OP_MUL, OP_NOT};
    vals = '{16'd1, 16'd5, 16'd8, 16'd2, 16'd3, 16'd9};
    repeat (2) @(posedge clk);
    #1 rst = 0;
    chk("rst_acc", acc, 0);
    chk("rst_rsp_valid", 32'(rsp_valid), 0);
    chk("rst_rsp_result", rsp_result, 0);
    chk("rst_rsp_err", 32'(rsp_err), 0);
    chk("rst_op_code", 32'(alu_op_code), 32'(OP_NOOP));
    chk("rst_input_a", 32'(alu_input_a), 0);
    chk("rst_cmd_ready", 32'(cmd_ready), 1);
    chk("rst_busy", 32'(busy), 0);

    push(OP_PRESET, 16'd0);
    ta = cyc;
    wait_rsp(t0);
    chk("lat_base", 32'(t0 - ta), 32'(BL + 1));
    @(posedge clk); #1;
    wait_idle();

    push(OP_RESET, 16'd0);
    push(OP_ADD, 16'd6);
    push(OP_ADD, 16'd6);
    wait_rsp(t0);
    @(posedge clk); #1;
    wait_rsp(t1);
    chk("b2b_gap1", 32'(t1 - t0), 32'(BL + 2));
    @(posedge clk); #1;
    wait_rsp(t2);
    chk("b2b_gap2", 32'(t2 - t1), 32'(BL + 2));
    @(posedge clk); #1;
    wait_idle();
    chk("acc_12", acc, 32'd12);

    push(OP_RESET, 16'd0);
    push(OP_DIV, 16'd6);
    wait_idle();
    chk("divz_acc", acc, 0);
    chk("divz_err", 32'(rsp_err), 32'h2);
    push(OP_ADD, 16'd3);
    wait_idle();
    push(OP_MOD, 16'd7);
    ta = cyc;
    wait_rsp(t0);
    chk("lat_muldiv", 32'(t0 - ta), 32'(ML + 1));
    chk("mod_result", rsp_result, 32'd1);
    @(posedge clk); #1;
    wait_idle();

    rsp_ready = 0;
    n_acc = 0;
    for (int i = 0; i < 6; i++) begin
      try_push(ops[i], vals[i], ok);
      n_acc += int'(ok);
    end
    chk("accepted", 32'(n_acc), 5);
    chk("full_ready", 32'(cmd_ready), 0);
    wait_rsp(t0);
    r0 = rsp_result; e0 = rsp_err; a0 = acc;
    repeat (5) begin
      @(posedge clk); #1;
    end
    chk("hold_valid", 32'(rsp_valid), 1);
    chk("hold_result", rsp_result, r0);
    chk("hold_err", 32'(rsp_err), 32'(e0));
    chk("hold_acc", acc, a0);
    rsp_ready = 1;
    wait_idle();
    chk("drained", 32'(sb.size()), 0);

    push(OP_RESET, 16'd0);
    push(OP_MUL, 16'd5);
    push(OP_ADD, 16'd1);
    wait_rsp(t0);
    repeat (3) begin
      @(posedge clk); #1;
    end
    chk("exec_op", 32'(alu_op_code), 32'(OP_MUL));
    chk("exec_a", 32'(alu_input_a), 32'd5);
    rst = 1;
    sb.delete();
    macc = 0;
    @(posedge clk); #1;
    rst = 0;
    chk("abort_acc", acc, 0);
    chk("abort_valid", 32'(rsp_valid), 0);
    chk("abort_op", 32'(alu_op_code), 32'(OP_NOOP));
    chk("abort_busy", 32'(busy), 0);
    repeat (10) begin
      @(posedge clk); #1;
    end
    chk("abort_no_rsp", 32'(rsp_valid), 0);
    chk("abort_acc_hold", acc, 0);

    push(OP_ADD, 16'd5);
    wait_idle();
    force_err = 1;
    push(OP_SUB, 16'd2);
    wait_rsp(t0);
    chk("sub_ovf", 32'(rsp_err), 32'h1);
    @(posedge clk); #1;
    wait_idle();
    push(OP_AND, 16'd3);
    wait_rsp(t0);
    chk("and_no_ovf", 32'(rsp_err), 32'h0);
    @(posedge clk); #1;
    wait_idle();
    force_err = 0;

    chk("sb_empty", 32'(sb.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
